// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified instruction/data SRAM port arbiter.
// Holds FSM states, response-owner IDs and the default SRAM word-address width.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } rsp_owner_e;

    localparam int ADDR_W_DEF = 8;
    localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count visible the cycle after inc/clr; no backpressure (holds at MAX).
module mem_port_arbiter_sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1RW SRAM between fetch and load/store; one access per cycle, D-lock for RMW.
// Latency: grant combinational, read data the cycle after grant; losers hold req (req/gnt handshake).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_e          state_q;
    rsp_owner_e          rsp_owner_q;
    logic                rsp_vld_q;
    logic [31:0]         if_rdata_q;
    logic [31:0]         d_rdata_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_full;
    logic                if_win;
    logic                d_win;
    logic                unused_addr_bits;

    assign starve_full = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Starvation only breaks ties in ARB; an open RMW lock is never preempted.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (reset) begin
            if (state_q == ST_LOCK) begin
                d_win = d_req;
            end else if (if_req && d_req) begin
                if (starve_full) begin
                    if_win = 1'b1;
                end else begin
                    d_win = 1'b1;
                end
            end else begin
                if_win = if_req;
                d_win  = d_req;
            end
        end
    end

    assign if_gnt   = if_win;
    assign d_gnt    = d_win;
    assign mem_csb  = ~(if_win | d_win);
    assign mem_web  = ~(d_win & d_we);
    assign mem_addr = d_win  ? d_addr[ADDR_W+1:2] :
                      if_win ? if_addr[ADDR_W+1:2] : '0;
    assign mem_din  = reset ? d_wdata : '0;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ARB;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= OWN_IF;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_ARB:  if (d_win && !d_we && d_lock) state_q <= ST_LOCK;
                ST_LOCK: if ((d_win && d_we) || (!d_req && !d_lock)) state_q <= ST_ARB;
            endcase
            rsp_vld_q <= if_win | (d_win & ~d_we);
            if (if_win) begin
                rsp_owner_q <= OWN_IF;
            end else if (d_win && !d_we) begin
                rsp_owner_q <= OWN_D;
            end
            // Hold registers keep the last word so the idle port's rdata stays stable.
            if (if_rvalid) if_rdata_q <= mem_dout;
            if (d_rvalid)  d_rdata_q  <= mem_dout;
        end
    end

    assign if_rvalid = rsp_vld_q & (rsp_owner_q == OWN_IF);
    assign d_rvalid  = rsp_vld_q & (rsp_owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_dout : if_rdata_q;
    assign d_rdata   = d_rvalid  ? mem_dout : d_rdata_q;

    mem_port_arbiter_sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (STARVE_W'(STARVE_LIMIT))
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (if_req & ~if_win),
        .clr_i (if_win),
        .cnt_o (starve_cnt)
    );

    mem_port_arbiter_sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_conflict_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (if_req & d_req),
        .clr_i (1'b0),
        .cnt_o (conflict_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, and a random run
// checked against a request-level model with its own shadow memory.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, d_lock;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_csb, mem_web;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic [CW-1:0] conflict_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
    );

    function automatic logic [31:0] pre(int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Behavioural SRAM: unwritten words read back their preload pattern.
    logic [31:0]  sram [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) begin
                sram[mem_addr]    <= mem_din;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_dout <= written[mem_addr] ? sram[mem_addr] : pre(int'(mem_addr));
            end
        end
    end

    logic [31:0] ref_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; d_we = 0; d_lock = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_csb;
        logic        e_web;
        logic [7:0]  e_addr;
        logic        e_if_rv;
        logic        e_d_rv;
        logic [3:0]  e_conf;
    } vec_t;

    vec_t tbl [8];

    // Random-phase model state
    int          m_starve, m_conf;
    bit          m_lock, m_rsp_vld, m_rsp_d, m_if_seen, m_d_seen;
    bit          e_if, e_d, n_vld, n_d;
    logic [31:0] m_rsp_dat, m_if_hold, m_d_hold, n_dat;

    initial begin
        reset = 1;
        idle_inputs();
        for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
        #2 reset = 0;

        //---------------- vector table, applied one row per cycle after reset
        tbl[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 32'h4,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3FC, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[5] = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 4'd0};
        tbl[6] = '{1'b1, 32'h8,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 4'd1};
        tbl[7] = '{1'b1, 32'hFFFFFC0C, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 4'd1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_if_gnt", i), 32'(if_gnt), 32'(tbl[i].e_if_gnt));
            chk($sformatf("tbl%0d_d_gnt", i), 32'(d_gnt), 32'(tbl[i].e_d_gnt));
            chk($sformatf("tbl%0d_csb", i), 32'(mem_csb), 32'(tbl[i].e_csb));
            chk($sformatf("tbl%0d_web", i), 32'(mem_web), 32'(tbl[i].e_web));
            if (!tbl[i].e_csb) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_if_rv", i), 32'(if_rvalid), 32'(tbl[i].e_if_rv));
            chk($sformatf("tbl%0d_d_rv", i), 32'(d_rvalid), 32'(tbl[i].e_d_rv));
            chk($sformatf("tbl%0d_conf", i), 32'(conflict_cnt), 32'(tbl[i].e_conf));
        end
        ref_mem[255] = 32'hDEADBEEF;

        //---------------- IF only, back-to-back fetches of words 0..2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            if_req = (k < 3); if_addr = 32'(4 * k);
            @(negedge clk);
            if (k < 3) begin
                chk("if_only_gnt", 32'(if_gnt), 32'd1);
                chk("if_only_addr", 32'(mem_addr), 32'(k));
            end
            if (k >= 1 && k <= 3) begin
                chk("if_only_rv", 32'(if_rvalid), 32'd1);
                chk("if_only_rdata", if_rdata, pre(k - 1));
            end
            if (k == 4) begin
                chk("if_only_rv_end", 32'(if_rvalid), 32'd0);
                chk("if_only_hold", if_rdata, pre(2));
            end
        end

        //---------------- write to top word, no rvalid, then readback
        do_reset();
        step();
        d_req = 1; d_we = 1; d_addr = 32'h3FC; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt", 32'(d_gnt), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'hFF);
        chk("wr_web", 32'(mem_web), 32'd0);
        chk("wr_din", mem_din, 32'hDEADBEEF);
        step();
        d_we = 0; d_wdata = 0;
        @(negedge clk);
        chk("wr_no_rv", 32'(d_rvalid), 32'd0);
        chk("rd_web", 32'(mem_web), 32'd1);
        step();
        d_req = 0;
        @(negedge clk);
        chk("rdbk_rv", 32'(d_rvalid), 32'd1);
        chk("rdbk_data", d_rdata, 32'hDEADBEEF);

        //---------------- contention: D wins until IF has lost LIMIT times
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            step();
            if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
            @(negedge clk);
            chk($sformatf("cont%0d_d_gnt", c), 32'(d_gnt), (c == 5) ? 32'd0 : 32'd1);
            chk($sformatf("cont%0d_if_gnt", c), 32'(if_gnt), (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_conf", c), 32'(conflict_cnt), 32'(c - 1));
        end
        step();
        idle_inputs();
        @(negedge clk);
        chk("cont_conf_total", 32'(conflict_cnt), 32'd6);

        //---------------- lock RMW on word 4 while IF keeps requesting
        do_reset();
        step();
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h10; if_req = 1; if_addr = 32'h0;
        @(negedge clk);
        chk("lock_rd_gnt", 32'(d_gnt), 32'd1);
        chk("lock_rd_addr", 32'(mem_addr), 32'd4);
        chk("lock_rd_if_gnt", 32'(if_gnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            d_req = 0;
            @(negedge clk);
            chk("lock_hold_if_gnt", 32'(if_gnt), 32'd0);
            chk("lock_hold_csb", 32'(mem_csb), 32'd1);
            if (c == 0) begin
                chk("lock_rd_rv", 32'(d_rvalid), 32'd1);
                chk("lock_rd_data", d_rdata, ref_mem[4]);
            end
        end
        step();
        d_req = 1; d_we = 1; d_lock = 0; d_wdata = ref_mem[4] | 32'h0000_00FF;
        @(negedge clk);
        chk("lock_wr_gnt", 32'(d_gnt), 32'd1);
        chk("lock_wr_if_gnt", 32'(if_gnt), 32'd0);
        chk("lock_wr_web", 32'(mem_web), 32'd0);
        ref_mem[4] = ref_mem[4] | 32'h0000_00FF;
        step();
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk("unlock_if_gnt", 32'(if_gnt), 32'd1);
        chk("unlock_addr", 32'(mem_addr), 32'd0);
        step();
        if_req = 0; d_req = 1; d_addr = 32'h10;
        @(negedge clk);
        chk("unlock_if_rv", 32'(if_rvalid), 32'd1);
        chk("unlock_if_data", if_rdata, ref_mem[0]);
        step();
        d_req = 0;
        @(negedge clk);
        chk("rmw_rdbk", d_rdata, ref_mem[4]);

        //---------------- conflict counter saturation, then address alias
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h8;
            @(negedge clk);
            if (c == 16) chk("sat_mid", 32'(conflict_cnt), 32'(CMAX));
        end
        step();
        idle_inputs();
        @(negedge clk);
        chk("sat_final", 32'(conflict_cnt), 32'(CMAX));
        step();
        d_req = 1; d_addr = 32'h400;
        @(negedge clk);
        chk("alias_addr", 32'(mem_addr), 32'd0);
        step();
        d_req = 0;
        @(negedge clk);
        chk("alias_data", d_rdata, ref_mem[0]);

        //---------------- reset asserted while a read is in flight
        do_reset();
        step();
        d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        chk("rst_rd_gnt", 32'(d_gnt), 32'd1);
        step();
        reset = 0; if_req = 1; d_req = 1;
        @(negedge clk);
        chk("rst_d_rv", 32'(d_rvalid), 32'd0);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_csb", 32'(mem_csb), 32'd1);
        chk("rst_web", 32'(mem_web), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        step();
        reset = 1; if_req = 0; d_req = 0;
        @(negedge clk);
        chk("rst_rel_d_rv", 32'(d_rvalid), 32'd0);
        chk("rst_rel_conf", 32'(conflict_cnt), 32'd0);

        //---------------- random requesters against the request-level model
        do_reset();
        m_starve = 0; m_conf = 0; m_lock = 0; m_rsp_vld = 0; m_rsp_d = 0;
        m_if_seen = 0; m_d_seen = 0; e_if = 0; e_d = 0;
        m_rsp_dat = 0; m_if_hold = 0; m_d_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (!if_req || e_if) begin
                if_req = ($urandom_range(0, 3) != 0);
                if_addr = $urandom();
            end else if ($urandom_range(0, 19) == 0) begin
                if_req = 0;
            end
            if (!d_req || e_d) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = m_lock ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                d_addr = $urandom();
                d_wdata = $urandom();
                d_lock = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 0;
            end

            @(negedge clk);
            e_if = 0; e_d = 0;
            if (m_lock) e_d = d_req;
            else if (if_req && d_req) begin
                if (m_starve == LIMIT) e_if = 1;
                else e_d = 1;
            end else begin
                e_if = if_req; e_d = d_req;
            end

            chk("rnd_if_gnt", 32'(if_gnt), 32'(e_if));
            chk("rnd_d_gnt", 32'(d_gnt), 32'(e_d));
            chk("rnd_csb", 32'(mem_csb), 32'(!(e_if || e_d)));
            chk("rnd_web", 32'(mem_web), 32'(!(e_d && d_we)));
            if (e_d) chk("rnd_d_addr", 32'(mem_addr), 32'(widx(d_addr)));
            if (e_if) chk("rnd_if_addr", 32'(mem_addr), 32'(widx(if_addr)));
            if (e_d && d_we) chk("rnd_din", mem_din, d_wdata);
            chk("rnd_if_rv", 32'(if_rvalid), 32'(m_rsp_vld && !m_rsp_d));
            chk("rnd_d_rv", 32'(d_rvalid), 32'(m_rsp_vld && m_rsp_d));
            if (m_rsp_vld && !m_rsp_d) chk("rnd_if_rdata", if_rdata, m_rsp_dat);
            else if (m_if_seen) chk("rnd_if_hold", if_rdata, m_if_hold);
            if (m_rsp_vld && m_rsp_d) chk("rnd_d_rdata", d_rdata, m_rsp_dat);
            else if (m_d_seen) chk("rnd_d_hold", d_rdata, m_d_hold);
            chk("rnd_conf", 32'(conflict_cnt), 32'(m_conf));

            n_vld = 0; n_d = 0; n_dat = 0;
            if (e_if) begin
                n_vld = 1; n_dat = ref_mem[widx(if_addr)];
            end
            if (e_d && d_we) ref_mem[widx(d_addr)] = d_wdata;
            if (e_d && !d_we) begin
                n_vld = 1; n_d = 1; n_dat = ref_mem[widx(d_addr)];
            end
            if (m_rsp_vld && m_rsp_d) begin m_d_hold = m_rsp_dat; m_d_seen = 1; end
            if (m_rsp_vld && !m_rsp_d) begin m_if_hold = m_rsp_dat; m_if_seen = 1; end
            m_rsp_vld = n_vld; m_rsp_d = n_d; m_rsp_dat = n_dat;
            if (if_req && d_req && m_conf < CMAX) m_conf++;
            if (e_if) m_starve = 0;
            else if (if_req && m_starve < LIMIT) m_starve++;
            if (!m_lock) m_lock = e_d && !d_we && d_lock;
            else if ((e_d && d_we) || (!d_req && !d_lock)) m_lock = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
